// File: rtl/nibble_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : nibble_seq_multiplier
// Purpose  : Sequential unsigned multiplier built around an external
//            combinational 4x4 multiplier. Each RUN cycle presents one
//            nibble pair on mul_a/mul_b. It takes the 8-bit product back on
//            mul_p in the same cycle and adds it, shifted into place, to a
//            2*OPW-bit accumulator. One operation takes N_NIBBLES^2 RUN
//            cycles.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            in_valid/ready - operand handshake (ready only in IDLE)
//            A_in, B_in     - OPW-bit unsigned operands
//            mul_a, mul_b   - nibbles driven to the 4x4 multiplier
//            mul_p          - 4x4 multiplier product (same-cycle return)
//            out_valid/ready- result handshake
//            Product        - 2*OPW-bit unsigned result
// Revision : 1.0 - initial release
// ============================================================================
module nibble_seq_multiplier #(
  parameter int N_NIBBLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*N_NIBBLES-1:0] A_in,
  input  logic [4*N_NIBBLES-1:0] B_in,
  output logic [3:0]             mul_a,
  output logic [3:0]             mul_b,
  input  logic [7:0]             mul_p,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*N_NIBBLES-1:0] Product
);

  localparam int c_OPW  = 4 * N_NIBBLES;
  localparam int c_RW   = 2 * c_OPW;
  localparam int c_NSQ  = N_NIBBLES * N_NIBBLES;
  localparam int c_IDXW = (c_NSQ > 1) ? $clog2(c_NSQ) : 1;
  localparam int c_NW   = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam int c_SHW  = $clog2(c_RW) + 1;

  localparam logic [c_IDXW-1:0] c_LAST  = c_IDXW'(c_NSQ - 1);
  localparam logic [c_NW-1:0]   c_NLAST = c_NW'(N_NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [c_OPW-1:0]  r_a;
  logic [c_OPW-1:0]  r_b;
  logic [c_RW-1:0]   r_acc;
  logic [c_RW-1:0]   r_product;
  logic [c_IDXW-1:0] r_idx;
  // i/j nibble indices are tracked alongside idx (i = idx mod N,
  // j = idx div N) so no divider is needed for non-power-of-two N.
  logic [c_NW-1:0]   r_i;
  logic [c_NW-1:0]   r_j;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_step;
  logic              w_last;
  logic              w_release;
  logic [c_SHW-1:0]  w_shamt;
  logic [c_RW-1:0]   w_addend;
  logic [c_RW-1:0]   w_sum;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    w_release   = 1'b0;
    mul_a       = 4'h0;
    mul_b       = 4'h0;
    case (r_state)
      S_IDLE: begin
        // in_ready must read low while reset is asserted, even though the
        // state register already sits in IDLE.
        in_ready = ~rst;
        if (in_valid && !rst) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        for (int k = 0; k < N_NIBBLES; k++) begin
          if (r_i == c_NW'(k)) mul_a = r_a[4*k +: 4];
          if (r_j == c_NW'(k)) mul_b = r_b[4*k +: 4];
        end
        if (r_idx == c_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Partial-product alignment: nibble pair (i,j) carries weight 16^(i+j).
  // The 8-bit product is zero-extended before shifting.
  // --------------------------------------------------------------------------
  always_comb begin
    w_shamt  = c_SHW'(4 * (int'(r_i) + int'(r_j)));
    w_addend = c_RW'(mul_p) << w_shamt;
    w_sum    = r_acc + w_addend;
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_a   <= A_in;
      r_b   <= B_in;
      r_acc <= '0;
      r_idx <= '0;
      r_i   <= '0;
      r_j   <= '0;
    end else if (w_step) begin
      r_acc <= w_sum;
      r_idx <= r_idx + 1'b1;
      if (r_i == c_NLAST) begin
        r_i <= '0;
        r_j <= r_j + 1'b1;
      end else begin
        r_i <= r_i + 1'b1;
      end
      if (w_last) begin
        r_product   <= w_sum;
        r_out_valid <= 1'b1;
      end
    end else if (w_release) begin
      // Product is intentionally left holding the last result.
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign Product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_nibble_seq_multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nibble_seq_multiplier
// Purpose  : Self-checking bench for nibble_seq_multiplier at N=1, 2 and 3.
//            The external 4x4 multiplier is modelled as plain a*b. Expected
//            results are the arithmetic products of the operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_seq_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- N = 2 ----------------
  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0]  A2, B2, mul_p2;
  logic [3:0]  mul_a2, mul_b2;
  logic [15:0] P2;
  assign mul_p2 = {4'h0, mul_a2} * {4'h0, mul_b2};

  nibble_seq_multiplier #(.N_NIBBLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .A_in(A2), .B_in(B2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2),
    .out_valid(out_valid2), .out_ready(out_ready2), .Product(P2)
  );

  // ---------------- N = 1 ----------------
  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [3:0]  A1, B1, mul_a1, mul_b1;
  logic [7:0]  mul_p1, P1;
  assign mul_p1 = {4'h0, mul_a1} * {4'h0, mul_b1};

  nibble_seq_multiplier #(.N_NIBBLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .A_in(A1), .B_in(B1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1),
    .out_valid(out_valid1), .out_ready(out_ready1), .Product(P1)
  );

  // ---------------- N = 3 ----------------
  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  logic [11:0] A3, B3;
  logic [3:0]  mul_a3, mul_b3;
  logic [7:0]  mul_p3;
  logic [23:0] P3;
  assign mul_p3 = {4'h0, mul_a3} * {4'h0, mul_b3};

  nibble_seq_multiplier #(.N_NIBBLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .A_in(A3), .B_in(B3), .mul_a(mul_a3), .mul_b(mul_b3), .mul_p(mul_p3),
    .out_valid(out_valid3), .out_ready(out_ready3), .Product(P3)
  );

  // All tasks start and end just after a falling edge.

  // One full N=2 operation: accept, latency, result, optional stall, release.
  // While busy, junk operands are offered on in_valid and must be ignored.
  task automatic run2(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input int stall, input string name);
    int lat;
    out_ready2 = (stall == 0);
    A2 = a; B2 = b; in_valid2 = 1'b1;
    n_tests++;
    if (in_ready2 !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready_before_accept: got %b required 1", name, in_ready2);
    end
    @(negedge clk);
    in_valid2 = 1'b0;
    lat = 0;
    while (out_valid2 !== 1'b1 && lat < 100) begin
      in_valid2 = 1'($urandom); A2 = 8'($urandom); B2 = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid2 = 1'b0;
    n_tests++;
    if (lat != 4) begin
      n_fail++; $display("FAIL %s latency: got %0d required 4", name, lat);
    end
    n_tests++;
    if (P2 !== exp || mul_a2 !== 4'h0 || mul_b2 !== 4'h0) begin
      n_fail++; $display("FAIL %s product: got %h mul_a=%h mul_b=%h required %h,0,0", name, P2, mul_a2, mul_b2, exp);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid2 !== 1'b1 || P2 !== exp || in_ready2 !== 1'b0) begin
        n_fail++; $display("FAIL %s stall_hold: got ov=%b P=%h ir=%b required 1,%h,0", name, out_valid2, P2, in_ready2, exp);
      end
    end
    out_ready2 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1 || P2 !== exp) begin
      n_fail++; $display("FAIL %s release: got ov=%b ir=%b P=%h required 0,1,%h", name, out_valid2, in_ready2, P2, exp);
    end
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] exp, input string name);
    int lat;
    out_ready1 = 1'b1;
    A1 = a; B1 = b; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (out_valid1 !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (lat != 1) begin
      n_fail++; $display("FAIL %s latency: got %0d required 1", name, lat);
    end
    n_tests++;
    if (P1 !== exp) begin
      n_fail++; $display("FAIL %s product: got %h required %h", name, P1, exp);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL %s release: got ov=%b ir=%b required 0,1", name, out_valid1, in_ready1);
    end
  endtask

  task automatic run3(input logic [11:0] a, input logic [11:0] b,
                      input int stall, input string name);
    int lat;
    logic [23:0] exp;
    exp = 24'(a) * 24'(b);
    out_ready3 = (stall == 0);
    A3 = a; B3 = b; in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
    lat = 0;
    while (out_valid3 !== 1'b1 && lat < 100) begin
      in_valid3 = 1'($urandom); A3 = 12'($urandom); B3 = 12'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid3 = 1'b0;
    n_tests++;
    if (lat != 9) begin
      n_fail++; $display("FAIL %s latency: got %0d required 9", name, lat);
    end
    n_tests++;
    if (P3 !== exp) begin
      n_fail++; $display("FAIL %s product: a=%h b=%h got %h required %h", name, a, b, P3, exp);
    end
    repeat (stall) @(negedge clk);
    out_ready3 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1 || P3 !== exp) begin
      n_fail++; $display("FAIL %s release: got ov=%b ir=%b P=%h required 0,1,%h", name, out_valid3, in_ready3, P3, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (in_ready2 !== 1'b0 || out_valid2 !== 1'b0 || P2 !== 16'h0 ||
        mul_a2 !== 4'h0 || mul_b2 !== 4'h0) begin
      n_fail++; $display("FAIL reset_state: ir=%b ov=%b P=%h ma=%h mb=%h required 0,0,0000,0,0",
                         in_ready2, out_valid2, P2, mul_a2, mul_b2);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready2 !== 1'b1 || in_ready1 !== 1'b1 || in_ready3 !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b%b%b required 111", in_ready1, in_ready2, in_ready3);
    end
    @(negedge clk);
  endtask

  task automatic test_max();
    run2(8'hFF, 8'hFF, 16'hFE01, 0, "max_ff_ff");
  endtask

  task automatic test_nibble_seq();
    logic [3:0] ea [4];
    logic [3:0] eb [4];
    ea = '{4'h2, 4'h1, 4'h2, 4'h1};
    eb = '{4'h4, 4'h4, 4'h3, 4'h3};
    out_ready2 = 1'b1;
    A2 = 8'h12; B2 = 8'h34; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (mul_a2 !== ea[k] || mul_b2 !== eb[k]) begin
        n_fail++; $display("FAIL nibble_seq step%0d: got (%h,%h) required (%h,%h)", k, mul_a2, mul_b2, ea[k], eb[k]);
      end
      @(negedge clk);
    end
    n_tests++;
    if (out_valid2 !== 1'b1 || P2 !== 16'h03A8) begin
      n_fail++; $display("FAIL nibble_seq product: got ov=%b P=%h required 1,03a8", out_valid2, P2);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_operand();
    run2(8'h00, 8'hA5, 16'h0000, 0, "zero_a");
    run2(8'hA5, 8'h01, 16'h00A5, 1, "unit_b");
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    int lat;
    exp = 16'hAB * 16'hCD;
    out_ready2 = 1'b0;
    A2 = 8'hAB; B2 = 8'hCD; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    lat = 0;
    while (out_valid2 !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (lat != 4) begin
      n_fail++; $display("FAIL backpressure latency: got %0d required 4", lat);
    end
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_valid2 = 1'b1; A2 = 8'h0F; B2 = 8'h01;
      end else begin
        in_valid2 = 1'b0;
      end
      @(negedge clk);
      n_tests++;
      if (out_valid2 !== 1'b1 || P2 !== exp || in_ready2 !== 1'b0) begin
        n_fail++; $display("FAIL backpressure hold%0d: got ov=%b P=%h ir=%b required 1,%h,0", c, out_valid2, P2, in_ready2, exp);
      end
    end
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1 || P2 !== exp) begin
      n_fail++; $display("FAIL backpressure release: got ov=%b ir=%b P=%h required 0,1,%h", out_valid2, in_ready2, P2, exp);
    end
    repeat (6) @(negedge clk);
    n_tests++;
    if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1 || P2 !== exp) begin
      n_fail++; $display("FAIL backpressure no_capture: got ov=%b ir=%b P=%h required 0,1,%h", out_valid2, in_ready2, P2, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    out_ready2 = 1'b1;
    A2 = 8'hFF; B2 = 8'hFF; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mul_a2 !== 4'hF || mul_b2 !== 4'hF) begin
      n_fail++; $display("FAIL midrun_active: got (%h,%h) required (f,f)", mul_a2, mul_b2);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid2 !== 1'b0 || P2 !== 16'h0 || mul_a2 !== 4'h0 || mul_b2 !== 4'h0 || in_ready2 !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset: got ov=%b P=%h ma=%h mb=%h ir=%b required 0,0000,0,0,0",
                         out_valid2, P2, mul_a2, mul_b2, in_ready2);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready2 !== 1'b1) begin
      n_fail++; $display("FAIL midrun_release_ready: got %b required 1", in_ready2);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid2 !== 1'b0) begin
        n_fail++; $display("FAIL midrun_stale_valid cycle%0d: got %b required 0", c, out_valid2);
      end
    end
    run2(8'h03, 8'h05, 16'h000F, 0, "post_reset_op");
  endtask

  task automatic test_n1();
    run1(4'hF, 4'hD, 8'hC3, "n1_f_d");
    for (int n = 0; n < 20; n++) begin
      logic [3:0] a, b;
      a = 4'($urandom); b = 4'($urandom);
      run1(a, b, 8'(a) * 8'(b), "n1_rand");
    end
  endtask

  task automatic test_random_n2();
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] a, b;
      a = 8'($urandom); b = 8'($urandom);
      run2(a, b, 16'(a) * 16'(b), int'($urandom_range(0, 3)), "rand_n2");
    end
  endtask

  task automatic test_random_n3();
    for (int n = 0; n < 1000; n++) begin
      run3(12'($urandom), 12'($urandom), int'($urandom_range(0, 2)), "rand_n3");
    end
    run3(12'hFFF, 12'hFFF, 0, "n3_max");
  endtask

  initial begin
    rst = 1'b1;
    in_valid1 = 1'b0; in_valid2 = 1'b0; in_valid3 = 1'b0;
    out_ready1 = 1'b1; out_ready2 = 1'b1; out_ready3 = 1'b1;
    A1 = '0; B1 = '0; A2 = '0; B2 = '0; A3 = '0; B3 = '0;
    test_reset();
    test_max();
    test_nibble_seq();
    test_zero_operand();
    test_backpressure();
    test_reset_mid_run();
    test_n1();
    test_random_n2();
    test_random_n3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
